// File: rtl/bus_dest_regs.sv
// Bus destination register file: r0-r15, hi, lo, pc and mdr captured from the shared bus,
// with pc auto-increment, memory-side mdr load, load acknowledge, load counter and illegal-dest flag.
module bus_dest_regs #(
    parameter int unsigned PC_STEP = 4
) (
    input  logic        clk,
    input  logic        clear,
    input  logic [31:0] busMuxOut,
    input  logic [4:0]  destSel,
    input  logic        ldEn,
    input  logic        pcInc,
    input  logic        mdrRead,
    input  logic [31:0] memDataIn,
    output logic [31:0] r0,
    output logic [31:0] r1,
    output logic [31:0] r2,
    output logic [31:0] r3,
    output logic [31:0] r4,
    output logic [31:0] r5,
    output logic [31:0] r6,
    output logic [31:0] r7,
    output logic [31:0] r8,
    output logic [31:0] r9,
    output logic [31:0] r10,
    output logic [31:0] r11,
    output logic [31:0] r12,
    output logic [31:0] r13,
    output logic [31:0] r14,
    output logic [31:0] r15,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] pc,
    output logic [31:0] mdr,
    output logic        ldDone,
    output logic        illegalDest,
    output logic [15:0] loadCount
);

    localparam logic [4:0] SEL_HI  = 5'b10000;
    localparam logic [4:0] SEL_LO  = 5'b10001;
    localparam logic [4:0] SEL_PC  = 5'b10100;
    localparam logic [4:0] SEL_MDR = 5'b10101;

    typedef struct packed {
        logic [15:1][31:0] gpr;
        logic [31:0]       hi;
        logic [31:0]       lo;
        logic [31:0]       pc;
        logic [31:0]       mdr;
    } regs_t;

    regs_t       regs_q, regs_d;
    logic        ld_done_q, ld_done_d;
    logic        illegal_q, illegal_d;
    logic [15:0] load_count_q, load_count_d;

    logic dest_gpr;
    logic dest_special;
    logic dest_illegal;
    logic mdr_conflict;
    logic ld_accept;

    always_comb begin
        dest_gpr     = (destSel[4] == 1'b0) && (destSel != 5'd0);
        dest_special = (destSel == SEL_HI) || (destSel == SEL_LO) ||
                       (destSel == SEL_PC) || (destSel == SEL_MDR);
        dest_illegal = destSel[4] && !dest_special;
        // Memory read wins over a bus load into mdr; that load is not acknowledged.
        mdr_conflict = ldEn && mdrRead && (destSel == SEL_MDR);
        ld_accept    = ldEn && (dest_gpr || dest_special) && !mdr_conflict;
    end

    always_comb begin
        regs_d = regs_q;
        if (pcInc)
            regs_d.pc = regs_q.pc + 32'(PC_STEP);
        if (mdrRead)
            regs_d.mdr = memDataIn;
        if (ld_accept) begin
            for (int i = 1; i < 16; i++) begin
                if (dest_gpr && (destSel[3:0] == 4'(i)))
                    regs_d.gpr[i] = busMuxOut;
            end
            case (destSel)
                SEL_HI:  regs_d.hi  = busMuxOut;
                SEL_LO:  regs_d.lo  = busMuxOut;
                SEL_PC:  regs_d.pc  = busMuxOut;
                SEL_MDR: regs_d.mdr = busMuxOut;
                default: ;
            endcase
        end
    end

    always_comb begin
        ld_done_d    = ld_accept;
        illegal_d    = illegal_q || (ldEn && dest_illegal);
        load_count_d = load_count_q;
        if (ld_accept && (load_count_q != 16'hFFFF))
            load_count_d = load_count_q + 16'd1;
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            regs_q       <= '0;
            ld_done_q    <= 1'b0;
            illegal_q    <= 1'b0;
            load_count_q <= 16'd0;
        end else begin
            regs_q       <= regs_d;
            ld_done_q    <= ld_done_d;
            illegal_q    <= illegal_d;
            load_count_q <= load_count_d;
        end
    end

    assign r0          = 32'h0;
    assign r1          = regs_q.gpr[1];
    assign r2          = regs_q.gpr[2];
    assign r3          = regs_q.gpr[3];
    assign r4          = regs_q.gpr[4];
    assign r5          = regs_q.gpr[5];
    assign r6          = regs_q.gpr[6];
    assign r7          = regs_q.gpr[7];
    assign r8          = regs_q.gpr[8];
    assign r9          = regs_q.gpr[9];
    assign r10         = regs_q.gpr[10];
    assign r11         = regs_q.gpr[11];
    assign r12         = regs_q.gpr[12];
    assign r13         = regs_q.gpr[13];
    assign r14         = regs_q.gpr[14];
    assign r15         = regs_q.gpr[15];
    assign hi          = regs_q.hi;
    assign lo          = regs_q.lo;
    assign pc          = regs_q.pc;
    assign mdr         = regs_q.mdr;
    assign ldDone      = ld_done_q;
    assign illegalDest = illegal_q;
    assign loadCount   = load_count_q;

endmodule

// File: tb/tb_bus_dest_regs.sv
// Self-checking bench for bus_dest_regs: directed vector table, async-clear and saturation
// sequences, then randomized traffic against a destination-code-indexed reference model.
module tb_bus_dest_regs;

    logic        clk = 1'b0;
    logic        clear = 1'b1;
    logic [31:0] busMuxOut = '0;
    logic [4:0]  destSel = '0;
    logic        ldEn = 1'b0;
    logic        pcInc = 1'b0;
    logic        mdrRead = 1'b0;
    logic [31:0] memDataIn = '0;
    logic [31:0] r0, r1, r2, r3, r4, r5, r6, r7, r8, r9, r10, r11, r12, r13, r14, r15;
    logic [31:0] hi, lo, pc, mdr;
    logic        ldDone, illegalDest;
    logic [15:0] loadCount;

    int checks = 0;
    int errors = 0;

    bus_dest_regs #(.PC_STEP(4)) dut (
        .clk(clk), .clear(clear), .busMuxOut(busMuxOut), .destSel(destSel),
        .ldEn(ldEn), .pcInc(pcInc), .mdrRead(mdrRead), .memDataIn(memDataIn),
        .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5), .r6(r6), .r7(r7),
        .r8(r8), .r9(r9), .r10(r10), .r11(r11), .r12(r12), .r13(r13), .r14(r14), .r15(r15),
        .hi(hi), .lo(lo), .pc(pc), .mdr(mdr),
        .ldDone(ldDone), .illegalDest(illegalDest), .loadCount(loadCount)
    );

    always #5 clk = ~clk;

    // Reference model: one slot per destination code; slot 0 is never written.
    logic [31:0] m_reg [32];
    logic        m_done;
    logic        m_ill;
    int          m_cnt;

    function automatic bit writable(input logic [4:0] s);
        return (s >= 5'd1 && s <= 5'd17) || s == 5'd20 || s == 5'd21;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_reg[i] = '0;
        m_done = 1'b0;
        m_ill  = 1'b0;
        m_cnt  = 0;
    endtask

    task automatic model_step();
        logic [31:0] nxt [32];
        bit acc;
        for (int i = 0; i < 32; i++) nxt[i] = m_reg[i];
        acc = ldEn && writable(destSel) && !(destSel == 5'd21 && mdrRead);
        if (pcInc)   nxt[20] = m_reg[20] + 32'd4;
        if (mdrRead) nxt[21] = memDataIn;
        if (acc)     nxt[destSel] = busMuxOut;
        for (int i = 0; i < 32; i++) m_reg[i] = nxt[i];
        m_done = acc;
        if (acc && m_cnt < 65535) m_cnt++;
        if (ldEn && destSel != 5'd0 && !writable(destSel)) m_ill = 1'b1;
    endtask

    function automatic logic [31:0] dut_reg(input int c);
        case (c)
            0: return r0;   1: return r1;   2: return r2;   3: return r3;
            4: return r4;   5: return r5;   6: return r6;   7: return r7;
            8: return r8;   9: return r9;   10: return r10; 11: return r11;
            12: return r12; 13: return r13; 14: return r14; 15: return r15;
            16: return hi;  17: return lo;  20: return pc;  21: return mdr;
            default: return 32'hX;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        for (int c = 0; c < 22; c++) begin
            if (c == 18 || c == 19) continue;
            chk($sformatf("%s reg%0d", tag, c), dut_reg(c), m_reg[c]);
        end
        chk({tag, " ldDone"}, 32'(ldDone), 32'(m_done));
        chk({tag, " illegalDest"}, 32'(illegalDest), 32'(m_ill));
        chk({tag, " loadCount"}, 32'(loadCount), 32'(m_cnt));
    endtask

    task automatic tick(input string tag, input bit do_check);
        @(posedge clk);
        #1;
        if (clear) model_step();
        if (do_check) check_all(tag);
    endtask

    task automatic idle_inputs();
        ldEn = 0; pcInc = 0; mdrRead = 0; destSel = '0; busMuxOut = '0; memDataIn = '0;
    endtask

    task automatic pulse_clear();
        #3 clear = 1'b0;
        #1 model_reset();
        @(posedge clk);
        #3 clear = 1'b1;
    endtask

    typedef struct packed {
        logic        ld;
        logic [4:0]  sel;
        logic [31:0] bus;
        logic        pci;
        logic        mrd;
        logic [31:0] mem;
        logic [4:0]  chk_sel;
        logic [31:0] chk_val;
        logic        e_done;
        logic        e_ill;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vt [12];

    initial begin
        vt[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 1'b0, 32'h0,        5'd5,  32'hDEADBEEF, 1'b1, 1'b0, 16'd1};
        vt[1]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 1'b0, 32'h0,        5'd0,  32'h00000000, 1'b0, 1'b0, 16'd1};
        vt[2]  = '{1'b1, 5'd18, 32'h00001111, 1'b0, 1'b0, 32'h0,        5'd5,  32'hDEADBEEF, 1'b0, 1'b1, 16'd1};
        vt[3]  = '{1'b0, 5'd0,  32'h00000000, 1'b0, 1'b0, 32'h0,        5'd5,  32'hDEADBEEF, 1'b0, 1'b1, 16'd1};
        vt[4]  = '{1'b1, 5'd20, 32'hFFFFFFFC, 1'b0, 1'b0, 32'h0,        5'd20, 32'hFFFFFFFC, 1'b1, 1'b1, 16'd2};
        vt[5]  = '{1'b0, 5'd0,  32'h00000000, 1'b1, 1'b0, 32'h0,        5'd20, 32'h00000000, 1'b0, 1'b1, 16'd2};
        vt[6]  = '{1'b1, 5'd20, 32'h00000100, 1'b1, 1'b0, 32'h0,        5'd20, 32'h00000100, 1'b1, 1'b1, 16'd3};
        vt[7]  = '{1'b1, 5'd21, 32'hAAAAAAAA, 1'b0, 1'b1, 32'h12345678, 5'd21, 32'h12345678, 1'b0, 1'b1, 16'd3};
        vt[8]  = '{1'b1, 5'd16, 32'h13579BDF, 1'b1, 1'b1, 32'hCAFEF00D, 5'd20, 32'h00000104, 1'b1, 1'b1, 16'd4};
        vt[9]  = '{1'b1, 5'd17, 32'h2468ACE0, 1'b0, 1'b0, 32'h0,        5'd21, 32'hCAFEF00D, 1'b1, 1'b1, 16'd5};
        vt[10] = '{1'b1, 5'd15, 32'h0F0F0F0F, 1'b0, 1'b0, 32'h0,        5'd16, 32'h13579BDF, 1'b1, 1'b1, 16'd6};
        vt[11] = '{1'b1, 5'd31, 32'h77777777, 1'b0, 1'b0, 32'h0,        5'd15, 32'h0F0F0F0F, 1'b0, 1'b1, 16'd6};

        // Power-up reset
        #1 clear = 1'b0;
        model_reset();
        #2 check_all("reset");
        @(negedge clk);
        clear = 1'b1;

        // Directed vector table
        for (int i = 0; i < 12; i++) begin
            ldEn = vt[i].ld; destSel = vt[i].sel; busMuxOut = vt[i].bus;
            pcInc = vt[i].pci; mdrRead = vt[i].mrd; memDataIn = vt[i].mem;
            tick($sformatf("vec%0d", i), 1'b1);
            chk($sformatf("vec%0d target", i), dut_reg(int'(vt[i].chk_sel)), vt[i].chk_val);
            chk($sformatf("vec%0d done", i), 32'(ldDone), 32'(vt[i].e_done));
            chk($sformatf("vec%0d ill", i), 32'(illegalDest), 32'(vt[i].e_ill));
            chk($sformatf("vec%0d cnt", i), 32'(loadCount), 32'(vt[i].e_cnt));
        end
        idle_inputs();
        tick("idle", 1'b1);

        // Async clear in the middle of a held r7 load
        ldEn = 1; destSel = 5'd7;
        for (int i = 0; i < 3; i++) begin
            busMuxOut = 32'hA5A50000 + 32'(i);
            tick($sformatf("r7hold%0d", i), 1'b1);
        end
        #3 clear = 1'b0;
        #1 model_reset();
        check_all("async_clear");
        chk("async_clear r7", r7, 32'h0);
        pcInc = 1; mdrRead = 1; memDataIn = 32'h55555555;
        tick("held_clear", 1'b1);
        #3 clear = 1'b1;
        pcInc = 0; mdrRead = 0;
        busMuxOut = 32'h00C0FFEE;
        tick("resume", 1'b1);
        chk("resume r7", r7, 32'h00C0FFEE);
        chk("resume cnt", 32'(loadCount), 32'd1);
        idle_inputs();

        // Load counter saturation
        pulse_clear();
        ldEn = 1; destSel = 5'd1;
        for (int i = 0; i < 65536; i++) begin
            busMuxOut = 32'(i);
            tick("sat", 1'b0);
        end
        chk("sat cnt", 32'(loadCount), 32'h0000FFFF);
        busMuxOut = 32'hBEEFBEEF;
        tick("sat_extra", 1'b1);
        chk("sat_extra cnt", 32'(loadCount), 32'h0000FFFF);
        chk("sat_extra r1", r1, 32'hBEEFBEEF);
        idle_inputs();

        // Randomized traffic
        pulse_clear();
        for (int i = 0; i < 3000; i++) begin
            ldEn      = ($urandom_range(0, 9) < 7);
            destSel   = 5'($urandom_range(0, 31));
            busMuxOut = $urandom;
            pcInc     = ($urandom_range(0, 9) < 3);
            mdrRead   = ($urandom_range(0, 9) < 3);
            memDataIn = $urandom;
            tick("rand", 1'b1);
            if (i % 1000 == 999) begin
                idle_inputs();
                pulse_clear();
            end
        end
        idle_inputs();
        tick("final", 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_dest_regs.md
BUS_DEST_REGS -- requirements
Module: bus_dest_regs

Interface
REQ-001 SHALL have parameter PC_STEP, default 4, giving the PC increment per pcInc pulse.
REQ-002 SHALL have port clk, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-003 SHALL have port clear, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port busMuxOut, input, 32 bits: shared bus value to be captured.
REQ-005 SHALL have port destSel, input, 5 bits: destination code, same numbering as bus source codes (00000-01111 r0-r15, 10000 hi, 10001 lo, 10100 pc, 10101 mdr).
REQ-006 SHALL have port ldEn, input, 1 bit: load strobe; capture busMuxOut into destSel target this edge.
REQ-007 SHALL have port pcInc, input, 1 bit: advance pc by PC_STEP this edge.
REQ-008 SHALL have port mdrRead, input, 1 bit: load mdr from memDataIn this edge.
REQ-009 SHALL have port memDataIn, input, 32 bits: memory read data.
REQ-010 SHALL have ports r0..r15, hi, lo, pc, mdr, outputs, 32 bits each: current register contents, fed to the bus source selector.
REQ-011 SHALL have port ldDone, output, 1 bit: one-cycle acknowledge of an accepted load.
REQ-012 SHALL have port illegalDest, output, 1 bit: sticky flag, non-writable destination attempted.
REQ-013 SHALL have port loadCount, output, 16 bits: count of accepted loads.

Function
REQ-014 SHALL, on a rising edge with ldEn=1 and a writable destSel, write busMuxOut to that register, visible at the output the same edge.
REQ-015 SHALL treat writable codes as 00001-01111, 10000, 10001, 10100, 10101.
REQ-016 SHALL hold r0 at 32'h0 permanently; ldEn with destSel=00000 is discarded and is neither accepted nor illegal.
REQ-017 SHALL treat 10010, 10011, 10110, 10111 and 11000-11111 as non-writable: no register changes, illegalDest set to 1 on that edge.
REQ-018 SHALL keep illegalDest at 1 until clear is asserted.
REQ-019 SHALL drive ldDone high for exactly the one cycle following an accepted load (REQ-014) and low otherwise; back-to-back loads give ldDone high on consecutive cycles.
REQ-020 SHALL increment loadCount by 1 per accepted load, saturating at 16'hFFFF.
REQ-021 SHALL, on pcInc=1, set pc to pc+PC_STEP modulo 2^32 (FFFFFFFC+4 wraps to 00000000).
REQ-022 SHALL, when ldEn targets pc and pcInc=1 on the same edge, load busMuxOut and ignore the increment.
REQ-023 SHALL, on mdrRead=1, set mdr to memDataIn.
REQ-024 SHALL, when ldEn targets mdr and mdrRead=1 on the same edge, load memDataIn, discard the bus value, and count the load as not accepted (no ldDone, no loadCount change).
REQ-025 SHALL leave all registers unchanged on edges with ldEn, pcInc and mdrRead all 0.
REQ-026 SHALL apply pcInc and mdrRead independently of, and concurrently with, a load to any other destination.

Reset
REQ-027 SHALL, while clear=0, immediately force r0-r15, hi, lo, pc, mdr to 32'h0, loadCount to 0, ldDone to 0, illegalDest to 0, independent of clk.
REQ-028 SHALL ignore ldEn, pcInc and mdrRead while clear=0, including when asserted mid-operation; no partial write survives.
REQ-029 SHALL resume normal operation on the first rising edge after clear returns to 1.

Verification
REQ-030 SHALL verify the load path: busMuxOut=32'hDEADBEEF, destSel=00101, ldEn=1 for one edge -> r5=DEADBEEF, ldDone=1 the next cycle, loadCount=1, all other registers 0.
REQ-031 SHALL verify r0 and illegal codes: ldEn=1 with destSel=00000 then 10010 -> r0=0, no ldDone, illegalDest=0 then 1 and stays 1, loadCount unchanged.
REQ-032 SHALL verify pc priority and wrap: pc=FFFFFFFC, pcInc=1 -> pc=00000000; then pcInc=1 with ldEn to pc, bus=00000100 -> pc=00000100.
REQ-033 SHALL verify the mdr conflict: mdrRead=1, memDataIn=12345678, ldEn to mdr with bus=AAAAAAAA -> mdr=12345678, ldDone=0, loadCount unchanged.
REQ-034 SHALL verify async clear: hold ldEn=1 to r7 for 3 cycles, drop clear mid-cycle -> all outputs 0 before the next edge, loadCount=0.
REQ-035 SHALL verify saturation: 65536 accepted loads -> loadCount=FFFF, unchanged after one further load.
